// File: rtl/vga_timing_pmod_if.sv
// rtl/vga_timing_pmod_if.sv - pixel-source link between the VGA timing generator and a colour core
// Signals:
//   hpos, vpos   - current horizontal / vertical counters
//   active       - coordinates lie inside the visible area
//   pix_tick     - one-clk pixel strobe
//   frame_start  - one-clk pulse on the tick that issues (0,0)
//   frame_cnt    - completed frames, wrapping
//   r_in, g_in, b_in - colour returned by the pixel source
// Modports: master = timing generator, slave = pixel source.
interface vga_timing_pmod_if #(
    parameter int HW         = 10,
    parameter int VW         = 10,
    parameter int FRAME_W    = 8,
    parameter int COLOR_BITS = 2
);
    logic [HW-1:0]         hpos;
    logic [VW-1:0]         vpos;
    logic                  active;
    logic                  pix_tick;
    logic                  frame_start;
    logic [FRAME_W-1:0]    frame_cnt;
    logic [COLOR_BITS-1:0] r_in;
    logic [COLOR_BITS-1:0] g_in;
    logic [COLOR_BITS-1:0] b_in;

    modport master (
        output hpos, vpos, active, pix_tick, frame_start, frame_cnt,
        input  r_in, g_in, b_in
    );

    modport slave (
        input  hpos, vpos, active, pix_tick, frame_start, frame_cnt,
        output r_in, g_in, b_in
    );
endinterface

// File: rtl/vga_timing_pmod.sv
// rtl/vga_timing_pmod.sv - parametrised VGA timing generator driving a TinyVGA PMOD bus
// Optional feature macro: DITHER_EN (2x2 ordered dither when COLOR_BITS > 2,
// otherwise colour channels are truncated to their two MSBs).
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   pix    - pixel-source interface (master side)
//   uo_out - registered PMOD bus {hsync, B[0], G[0], R[0], vsync, B[1], G[1], R[1]}
module vga_timing_pmod #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int CLK_DIV    = 1,
    parameter int PIPE_LAT   = 1,
    parameter int COLOR_BITS = 2,
    parameter int FRAME_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    vga_timing_pmod_if.master        pix,
    output logic [7:0]               uo_out
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [PW-1:0]       presc;
    logic [HW-1:0]       hpos;
    logic [VW-1:0]       vpos;
    logic [FRAME_W-1:0]  frame_cnt;
    logic                tick;
    logic                line_end;
    logic                frame_end;
    logic                raw_hs;
    logic                raw_vs;
    logic                raw_act;
    logic [PIPE_LAT-1:0] hs_d;
    logic [PIPE_LAT-1:0] vs_d;
    logic [PIPE_LAT-1:0] act_d;
    logic                hs_o;
    logic                vs_o;
    logic [1:0]          r2;
    logic [1:0]          g2;
    logic [1:0]          b2;

    assign tick      = (presc == PW'(CLK_DIV - 1));
    assign line_end  = (hpos == HW'(H_TOTAL - 1));
    assign frame_end = line_end && (vpos == VW'(V_TOTAL - 1));

    // Sync windows are compared in int so an end bound equal to the total
    // cannot alias through the narrow counter width.
    assign raw_hs  = (int'(hpos) >= H_ACTIVE + H_FP) && (int'(hpos) < H_ACTIVE + H_FP + H_SYNC);
    assign raw_vs  = (int'(vpos) >= V_ACTIVE + V_FP) && (int'(vpos) < V_ACTIVE + V_FP + V_SYNC);
    assign raw_act = (int'(hpos) < H_ACTIVE) && (int'(vpos) < V_ACTIVE);

    assign hs_o = hs_d[PIPE_LAT-1] ? HSYNC_POL : ~HSYNC_POL;
    assign vs_o = vs_d[PIPE_LAT-1] ? VSYNC_POL : ~VSYNC_POL;

    assign pix.hpos      = hpos;
    assign pix.vpos      = vpos;
    assign pix.active    = raw_act;
    assign pix.pix_tick  = tick;
    // Gated by rst_n so the pulse stays low while reset is held even when
    // CLK_DIV=1 makes the tick permanently high.
    assign pix.frame_start = rst_n && tick && (hpos == '0) && (vpos == '0);
    assign pix.frame_cnt = frame_cnt;

`ifdef DITHER_EN
    logic [PIPE_LAT-1:0] x_d;
    logic [PIPE_LAT-1:0] y_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_d <= '0;
            y_d <= '0;
        end else if (tick) begin
            for (int i = PIPE_LAT - 1; i > 0; i--) begin
                x_d[i] <= x_d[i-1];
                y_d[i] <= y_d[i-1];
            end
            x_d[0] <= hpos[0];
            y_d[0] <= vpos[0];
        end
    end

    if (COLOR_BITS > 2) begin : g_dither
        localparam int D   = COLOR_BITS - 2;
        localparam int SHL = (D >= 2) ? D - 2 : 0;
        localparam int SHR = (D >= 2) ? 0 : 2 - D;

        logic [1:0] idx;
        logic [1:0] bayer;

        // Threshold scaled to the discarded bits, added, then the two MSBs
        // of the sum are taken with saturation at full scale.
        function automatic logic [1:0] dith(input logic [COLOR_BITS-1:0] c,
                                            input logic [1:0] b);
            logic [COLOR_BITS:0] thr;
            logic [COLOR_BITS:0] sum;
            logic [COLOR_BITS:0] q;
            thr = ({{(COLOR_BITS-1){1'b0}}, b} << SHL) >> SHR;
            sum = {1'b0, c} + thr;
            q   = sum >> D;
            return (q > 3) ? 2'b11 : q[1:0];
        endfunction

        assign idx = {y_d[PIPE_LAT-1] ^ frame_cnt[0], x_d[PIPE_LAT-1]};

        always_comb begin
            bayer = 2'd0;
            case (idx)
                2'd0: bayer = 2'd0;
                2'd1: bayer = 2'd2;
                2'd2: bayer = 2'd3;
                2'd3: bayer = 2'd1;
                default: bayer = 2'd0;
            endcase
        end

        assign r2 = act_d[PIPE_LAT-1] ? dith(pix.r_in, bayer) : 2'b00;
        assign g2 = act_d[PIPE_LAT-1] ? dith(pix.g_in, bayer) : 2'b00;
        assign b2 = act_d[PIPE_LAT-1] ? dith(pix.b_in, bayer) : 2'b00;
    end else begin : g_trunc
        assign r2 = act_d[PIPE_LAT-1] ? pix.r_in[COLOR_BITS-1 -: 2] : 2'b00;
        assign g2 = act_d[PIPE_LAT-1] ? pix.g_in[COLOR_BITS-1 -: 2] : 2'b00;
        assign b2 = act_d[PIPE_LAT-1] ? pix.b_in[COLOR_BITS-1 -: 2] : 2'b00;
    end
`else
    assign r2 = act_d[PIPE_LAT-1] ? pix.r_in[COLOR_BITS-1 -: 2] : 2'b00;
    assign g2 = act_d[PIPE_LAT-1] ? pix.g_in[COLOR_BITS-1 -: 2] : 2'b00;
    assign b2 = act_d[PIPE_LAT-1] ? pix.b_in[COLOR_BITS-1 -: 2] : 2'b00;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc     <= '0;
            hpos      <= '0;
            vpos      <= '0;
            frame_cnt <= '0;
            hs_d      <= '0;
            vs_d      <= '0;
            act_d     <= '0;
            uo_out    <= {~HSYNC_POL, 3'b000, ~VSYNC_POL, 3'b000};
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                hpos <= line_end ? '0 : hpos + 1'b1;
                if (line_end) begin
                    vpos <= frame_end ? '0 : vpos + 1'b1;
                end
                if (frame_end) begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
                // Delay lines align syncs/blanking with the colour that the
                // pixel source returns PIPE_LAT ticks after the coordinates.
                for (int i = PIPE_LAT - 1; i > 0; i--) begin
                    hs_d[i]  <= hs_d[i-1];
                    vs_d[i]  <= vs_d[i-1];
                    act_d[i] <= act_d[i-1];
                end
                hs_d[0]  <= raw_hs;
                vs_d[0]  <= raw_vs;
                act_d[0] <= raw_act;
                uo_out   <= {hs_o, b2[0], g2[0], r2[0], vs_o, b2[1], g2[1], r2[1]};
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_pmod.sv
// tb/tb_vga_timing_pmod.sv - directed bench for vga_timing_pmod in a 16x8 total mode
module tb_vga_timing_pmod;
    logic       clk;
    logic       rst_a;
    logic       rst_b;
    logic [7:0] uo_a;
    logic [7:0] uo_b;
    int         checks;
    int         errors;

    vga_timing_pmod_if #(.HW(4), .VW(3), .FRAME_W(8), .COLOR_BITS(2)) ifa ();
    vga_timing_pmod_if #(.HW(4), .VW(3), .FRAME_W(8), .COLOR_BITS(2)) ifb ();

    vga_timing_pmod #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(1), .PIPE_LAT(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_a), .pix(ifa), .uo_out(uo_a)
    );

    vga_timing_pmod #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(3), .PIPE_LAT(3)
    ) dut_b (
        .clk(clk), .rst_n(rst_b), .pix(ifb), .uo_out(uo_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected PMOD byte for pixel index p (negative = nothing issued yet).
    function automatic logic [7:0] exp_uo(input int p);
        int h, v;
        logic hs, vs, act;
        logic [1:0] r, g, b;
        if (p < 0) return 8'h88;
        h   = p % 16;
        v   = (p / 16) % 8;
        hs  = (h >= 10) && (h < 13);
        vs  = (v >= 5) && (v < 7);
        act = (h < 8) && (v < 4);
        r   = act ? 2'(h) : 2'b00;
        g   = act ? 2'(v) : 2'b00;
        b   = act ? 2'(h >> 2) : 2'b00;
        return {~hs, b[0], g[0], r[0], ~vs, b[1], g[1], r[1]};
    endfunction

    // Colour source: drives raw colour of pixel p even in the border, so
    // blanking must come from the DUT.
    task automatic drive_colour(input int which, input int p);
        logic [1:0] r, g, b;
        int h, v;
        r = 2'b00; g = 2'b00; b = 2'b00;
        if (p >= 0) begin
            h = p % 16;
            v = (p / 16) % 8;
            r = 2'(h);
            g = 2'(v);
            b = 2'(h >> 2);
        end
        if (which == 0) begin
            ifa.r_in = r; ifa.g_in = g; ifa.b_in = b;
        end else begin
            ifb.r_in = r; ifb.g_in = g; ifb.b_in = b;
        end
    endtask

    task automatic sample(input int which, output logic [31:0] h, output logic [31:0] v,
                          output logic [31:0] act, output logic [31:0] tk,
                          output logic [31:0] fs, output logic [31:0] fc,
                          output logic [31:0] uo);
        if (which == 0) begin
            h = 32'(ifa.hpos); v = 32'(ifa.vpos); act = 32'(ifa.active);
            tk = 32'(ifa.pix_tick); fs = 32'(ifa.frame_start);
            fc = 32'(ifa.frame_cnt); uo = 32'(uo_a);
        end else begin
            h = 32'(ifb.hpos); v = 32'(ifb.vpos); act = 32'(ifb.active);
            tk = 32'(ifb.pix_tick); fs = 32'(ifb.frame_start);
            fc = 32'(ifb.frame_cnt); uo = 32'(uo_b);
        end
    endtask

    // Releases reset on a falling edge and checks every following cycle.
    task automatic run_dut(input int which, input int ncyc);
        int div, lat, k, eh, ev;
        logic tick_e;
        logic [31:0] h, v, act, tk, fs, fc, uo;
        div = (which == 0) ? 1 : 3;
        lat = (which == 0) ? 1 : 3;
        @(negedge clk);
        if (which == 0) rst_a = 1'b1; else rst_b = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            k      = c / div;
            tick_e = (c % div) == (div - 1);
            eh     = k % 16;
            ev     = (k / 16) % 8;
            drive_colour(which, k - lat);
            #1;
            sample(which, h, v, act, tk, fs, fc, uo);
            chk("hpos", h, 32'(eh));
            chk("vpos", v, 32'(ev));
            chk("active", act, 32'((eh < 8) && (ev < 4)));
            chk("pix_tick", tk, 32'(tick_e));
            chk("frame_start", fs, 32'(tick_e && (k % 128 == 0)));
            chk("frame_cnt", fc, 32'((k / 128) % 256));
            chk("uo_out", uo, 32'(exp_uo(k - 1 - lat)));
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] h, v, act, tk, fs, fc, uo;
        checks = 0;
        errors = 0;
        rst_a  = 1'b0;
        rst_b  = 1'b0;
        drive_colour(0, -1);
        drive_colour(1, -1);
        repeat (3) @(negedge clk);
        #1;

        sample(0, h, v, act, tk, fs, fc, uo);
        chk("rst_a uo_out", uo, 32'h88);
        chk("rst_a hpos", h, 32'd0);
        chk("rst_a vpos", v, 32'd0);
        chk("rst_a frame_start", fs, 32'd0);
        chk("rst_a frame_cnt", fc, 32'd0);
        sample(1, h, v, act, tk, fs, fc, uo);
        chk("rst_b uo_out", uo, 32'h88);
        chk("rst_b pix_tick", tk, 32'd0);
        chk("rst_b frame_start", fs, 32'd0);

        // Two full frames plus part of a third at CLK_DIV=1, PIPE_LAT=1.
        run_dut(0, 300);
        #2;
        rst_a = 1'b0;
        #1;
        sample(0, h, v, act, tk, fs, fc, uo);
        chk("reset2 uo_out", uo, 32'h88);
        chk("reset2 frame_cnt", fc, 32'd0);

        // Mid-line reset at (6,3): must clear asynchronously.
        run_dut(0, 54);
        #1;
        sample(0, h, v, act, tk, fs, fc, uo);
        chk("pre_rst hpos", h, 32'd6);
        chk("pre_rst vpos", v, 32'd3);
        chk("pre_rst uo_out", uo, 32'(exp_uo(52)));
        #1;
        rst_a = 1'b0;
        #1;
        sample(0, h, v, act, tk, fs, fc, uo);
        chk("midrst uo_out", uo, 32'h88);
        chk("midrst hpos", h, 32'd0);
        chk("midrst vpos", v, 32'd0);
        chk("midrst frame_start", fs, 32'd0);
        repeat (2) @(negedge clk);
        run_dut(0, 40);
        rst_a = 1'b0;

        // CLK_DIV=3, PIPE_LAT=3: one frame is 384 clocks.
        run_dut(1, 420);
        rst_b = 1'b0;
        #1;
        sample(1, h, v, act, tk, fs, fc, uo);
        chk("end rst_b uo_out", uo, 32'h88);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
